// File: rtl/connect4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : connect4_pkg
// Description : Shared constants for the Connect-4 move controller: board
//               dimensions, winner encodings, controller state encodings and
//               a helper mapping the side to move onto its winner code.
// Revision    : 1.0 - initial release
// ============================================================================
package connect4_pkg;

    // Board dimensions
    localparam int COLS = 7;
    localparam int ROWS = 6;

    // Winner encodings
    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;
    localparam logic [1:0] WIN_DRAW = 2'd3;

    // Controller states
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITE     = 2'd1;
    localparam logic [1:0] ST_CHECK     = 2'd2;
    localparam logic [1:0] ST_GAME_OVER = 2'd3;

    // Winner code for the side that just moved (0 = P1, 1 = P2)
    function automatic logic [1:0] winner_code(input logic side);
        return side ? WIN_P2 : WIN_P1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/connect4_col_heights.sv
`default_nettype none
// ============================================================================
// Module      : connect4_col_heights
// Description : Per-column fill heights of the Connect-4 board. One height
//               register per column, a single read port and an increment
//               strobe. A column that is already full never increments.
// Ports       : clk       - system clock
//               reset     - asynchronous active-high reset, clears all heights
//               clear     - synchronous clear of all heights (new game)
//               inc       - increment strobe for column inc_col
//               inc_col   - column to increment
//               rd_col    - column to read
//               rd_height - height of rd_col (0 for an out-of-range column)
//               rd_full   - rd_col holds ROWS pieces
// Revision    : 1.0 - initial release
// ============================================================================
module connect4_col_heights #(
    parameter int COLS  = 7,
    parameter int ROWS  = 6,
    parameter int COL_W = 3,
    parameter int ROW_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic [COL_W-1:0] inc_col,
    input  logic [COL_W-1:0] rd_col,
    output logic [ROW_W-1:0] rd_height,
    output logic             rd_full
);

    localparam logic [ROW_W-1:0] c_FULL = ROW_W'(ROWS);

    logic [ROW_W-1:0] r_height [COLS];

    generate
        for (genvar g = 0; g < COLS; g++) begin : g_col
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_height[g] <= '0;
                end else if (clear) begin
                    r_height[g] <= '0;
                end else if (inc && (inc_col == COL_W'(g)) && (r_height[g] != c_FULL)) begin
                    r_height[g] <= r_height[g] + 1'b1;
                end
            end
        end
    endgenerate

    // Read mux; column codes beyond COLS-1 read as empty
    always_comb begin
        rd_height = '0;
        for (int i = 0; i < COLS; i++) begin
            if (rd_col == COL_W'(i)) begin
                rd_height = r_height[i];
            end
        end
    end

    assign rd_full = (rd_height == c_FULL);

endmodule
`default_nettype wire

// File: rtl/connect4_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : connect4_move_ctrl
// Description : Connect-4 move controller. Turns debounced button pulses into
//               cursor moves and piece drops, issues one board write per
//               legal drop over a valid/ready handshake, then waits for the
//               win checker before passing the turn.
// Ports       : clk, reset             - clock, async active-high reset
//               btn_left/right/drop/new - one-cycle debounced button pulses
//               cursor_col, player      - cursor column, side to move
//               wr_valid/col/row/player - board write request (wr_ready in)
//               chk_done, chk_win       - win-check verdict for last write
//               reject                  - pulse: drop into a full column
//               new_game                - pulse: downstream clears the board
//               game_over, winner       - end-of-game status
// Revision    : 1.0 - initial release
// ============================================================================
module connect4_move_ctrl
    import connect4_pkg::*;
#(
    parameter int COLS      = connect4_pkg::COLS,
    parameter int ROWS      = connect4_pkg::ROWS,
    parameter int COL_W     = 3,
    parameter int ROW_W     = 3,
    parameter int START_COL = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_drop,
    input  logic             btn_new,
    output logic [COL_W-1:0] cursor_col,
    output logic             player,
    output logic             wr_valid,
    output logic [COL_W-1:0] wr_col,
    output logic [ROW_W-1:0] wr_row,
    output logic             wr_player,
    input  logic             wr_ready,
    input  logic             chk_done,
    input  logic             chk_win,
    output logic             reject,
    output logic             new_game,
    output logic             game_over,
    output logic [1:0]       winner
);

    localparam logic [COL_W-1:0] c_START    = COL_W'(START_COL);
    localparam logic [COL_W-1:0] c_LAST_COL = COL_W'(COLS - 1);
    localparam logic [5:0]       c_CELLS    = 6'(COLS * ROWS);

    logic [1:0]       r_state;
    logic [COL_W-1:0] r_cursor;
    logic             r_player;
    logic             r_wr_valid;
    logic [COL_W-1:0] r_wr_col;
    logic [ROW_W-1:0] r_wr_row;
    logic             r_wr_player;
    logic [5:0]       r_move_cnt;
    logic             r_reject;
    logic             r_new_game;
    logic [1:0]       r_winner;

    logic             w_accept;
    logic [ROW_W-1:0] w_height;
    logic             w_full;

    // A write completes only while WRITE holds the request
    assign w_accept = (r_state == ST_WRITE) && r_wr_valid && wr_ready;

    connect4_col_heights #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_heights (
        .clk       (clk),
        .reset     (reset),
        .clear     (btn_new),
        .inc       (w_accept),
        .inc_col   (r_wr_col),
        .rd_col    (r_cursor),
        .rd_height (w_height),
        .rd_full   (w_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cursor    <= c_START;
            r_player    <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_wr_col    <= '0;
            r_wr_row    <= '0;
            r_wr_player <= 1'b0;
            r_move_cnt  <= '0;
            r_reject    <= 1'b0;
            r_new_game  <= 1'b0;
            r_winner    <= WIN_NONE;
        end else begin
            r_reject   <= 1'b0;
            r_new_game <= 1'b0;
            if (btn_new) begin
                // New game overrides everything, including a pending write
                r_state     <= ST_IDLE;
                r_cursor    <= c_START;
                r_player    <= 1'b0;
                r_wr_valid  <= 1'b0;
                r_wr_col    <= '0;
                r_wr_row    <= '0;
                r_wr_player <= 1'b0;
                r_move_cnt  <= '0;
                r_winner    <= WIN_NONE;
                r_new_game  <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (btn_drop) begin
                            if (w_full) begin
                                r_reject <= 1'b1;
                            end else begin
                                r_wr_col    <= r_cursor;
                                r_wr_row    <= w_height;
                                r_wr_player <= r_player;
                                r_wr_valid  <= 1'b1;
                                r_state     <= ST_WRITE;
                            end
                        end else if (btn_left && !btn_right) begin
                            r_cursor <= (r_cursor == '0) ? c_LAST_COL : r_cursor - 1'b1;
                        end else if (btn_right && !btn_left) begin
                            r_cursor <= (r_cursor == c_LAST_COL) ? '0 : r_cursor + 1'b1;
                        end
                    end
                    ST_WRITE: begin
                        if (w_accept) begin
                            r_wr_valid <= 1'b0;
                            r_move_cnt <= r_move_cnt + 1'b1;
                            r_state    <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (chk_done) begin
                            if (chk_win) begin
                                r_winner <= winner_code(r_player);
                                r_state  <= ST_GAME_OVER;
                            end else if (r_move_cnt == c_CELLS) begin
                                // Board full without a winner
                                r_winner <= WIN_DRAW;
                                r_state  <= ST_GAME_OVER;
                            end else begin
                                r_player <= ~r_player;
                                r_state  <= ST_IDLE;
                            end
                        end
                    end
                    ST_GAME_OVER: begin
                        r_state <= ST_GAME_OVER;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign cursor_col = r_cursor;
    assign player     = r_player;
    assign wr_valid   = r_wr_valid;
    assign wr_col     = r_wr_col;
    assign wr_row     = r_wr_row;
    assign wr_player  = r_wr_player;
    assign reject     = r_reject;
    assign new_game   = r_new_game;
    assign game_over  = (r_state == ST_GAME_OVER);
    assign winner     = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_connect4_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_connect4_move_ctrl
// Description : Directed self-checking bench for connect4_move_ctrl. Inputs
//               change on the falling clock edge; outputs are compared on the
//               falling edge after the rising edge that consumed them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_connect4_move_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_drop = 1'b0;
    logic       btn_new = 1'b0;
    logic [2:0] cursor_col;
    logic       player;
    logic       wr_valid;
    logic [2:0] wr_col;
    logic [2:0] wr_row;
    logic       wr_player;
    logic       wr_ready = 1'b0;
    logic       chk_done = 1'b0;
    logic       chk_win = 1'b0;
    logic       reject;
    logic       new_game;
    logic       game_over;
    logic [1:0] winner;

    int checks = 0;
    int errors = 0;

    connect4_move_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_drop   (btn_drop),
        .btn_new    (btn_new),
        .cursor_col (cursor_col),
        .player     (player),
        .wr_valid   (wr_valid),
        .wr_col     (wr_col),
        .wr_row     (wr_row),
        .wr_player  (wr_player),
        .wr_ready   (wr_ready),
        .chk_done   (chk_done),
        .chk_win    (chk_win),
        .reject     (reject),
        .new_game   (new_game),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    // ---------------- stimulus helpers ----------------
    task automatic press_left();
        @(negedge clk) btn_left = 1'b1;
        @(negedge clk) btn_left = 1'b0;
    endtask

    task automatic press_right();
        @(negedge clk) btn_right = 1'b1;
        @(negedge clk) btn_right = 1'b0;
    endtask

    task automatic press_new();
        @(negedge clk) btn_new = 1'b1;
        @(negedge clk) btn_new = 1'b0;
    endtask

    task automatic goto_col(input int c);
        for (int k = 0; k < 8 && cursor_col != 3'(c); k++) press_right();
    endtask

    // Full fast move: drop, immediate handshake, immediate verdict.
    // Returns the write request as seen one cycle after the drop pulse.
    task automatic do_drop(input logic win, output logic v, output logic [2:0] col,
                           output logic [2:0] row, output logic pl);
        @(negedge clk) btn_drop = 1'b1;
        @(negedge clk) btn_drop = 1'b0;
        v = wr_valid; col = wr_col; row = wr_row; pl = wr_player;
        wr_ready = 1'b1;
        @(negedge clk) wr_ready = 1'b0;
        chk_done = 1'b1; chk_win = win;
        @(negedge clk) chk_done = 1'b0; chk_win = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cursor_col !== 3'd3) begin errors++; $display("FAIL reset_cursor: got %0d exp 3", cursor_col); end
        checks++; if (player !== 1'b0) begin errors++; $display("FAIL reset_player: got %0d exp 0", player); end
        checks++; if ({wr_valid, reject, new_game, game_over} !== 4'b0000) begin errors++;
            $display("FAIL reset_flags: got %b exp 0000", {wr_valid, reject, new_game, game_over}); end
        checks++; if (winner !== 2'd0) begin errors++; $display("FAIL reset_winner: got %0d exp 0", winner); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cursor();
        logic [2:0] exp_seq [4];
        exp_seq[0] = 3'd2; exp_seq[1] = 3'd1; exp_seq[2] = 3'd0; exp_seq[3] = 3'd6;
        for (int i = 0; i < 4; i++) begin
            press_left();
            checks++; if (cursor_col !== exp_seq[i]) begin errors++;
                $display("FAIL cursor_left_%0d: got %0d exp %0d", i, cursor_col, exp_seq[i]); end
        end
        press_right();
        checks++; if (cursor_col !== 3'd0) begin errors++; $display("FAIL cursor_right_wrap: got %0d exp 0", cursor_col); end
        @(negedge clk) begin btn_left = 1'b1; btn_right = 1'b1; end
        @(negedge clk) begin btn_left = 1'b0; btn_right = 1'b0; end
        checks++; if (cursor_col !== 3'd0) begin errors++; $display("FAIL cursor_both: got %0d exp 0", cursor_col); end
    endtask

    task automatic test_write_hold();
        goto_col(3);
        @(negedge clk) btn_drop = 1'b1;
        @(negedge clk) begin btn_drop = 1'b0; btn_left = 1'b1; end
        for (int i = 0; i < 5; i++) begin
            checks++; if ({wr_valid, wr_col, wr_row, wr_player} !== {1'b1, 3'd3, 3'd0, 1'b0}) begin errors++;
                $display("FAIL write_hold_%0d: got v=%0d c=%0d r=%0d p=%0d exp v=1 c=3 r=0 p=0",
                         i, wr_valid, wr_col, wr_row, wr_player); end
            @(negedge clk) btn_left = 1'b0;
        end
        checks++; if (cursor_col !== 3'd3) begin errors++; $display("FAIL write_cursor_frozen: got %0d exp 3", cursor_col); end
        wr_ready = 1'b1;
        @(negedge clk) wr_ready = 1'b0;
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL write_handshake: wr_valid got %0d exp 0", wr_valid); end
        checks++; if (player !== 1'b0) begin errors++; $display("FAIL check_wait_player: got %0d exp 0", player); end
        chk_done = 1'b1;
        @(negedge clk) chk_done = 1'b0;
        checks++; if (player !== 1'b1) begin errors++; $display("FAIL turn_pass: player got %0d exp 1", player); end
    endtask

    task automatic test_column_full();
        logic v, p;
        logic [2:0] c, r;
        press_new();
        goto_col(0);
        for (int i = 0; i < 6; i++) begin
            do_drop(1'b0, v, c, r, p);
            checks++; if ({v, c, r, p} !== {1'b1, 3'd0, 3'(i), 1'(i % 2)}) begin errors++;
                $display("FAIL fill_col0_%0d: got v=%0d c=%0d r=%0d p=%0d exp v=1 c=0 r=%0d p=%0d",
                         i, v, c, r, p, i, i % 2); end
        end
        @(negedge clk) btn_drop = 1'b1;
        @(negedge clk) btn_drop = 1'b0;
        checks++; if ({reject, wr_valid} !== 2'b10) begin errors++;
            $display("FAIL full_reject: got reject=%0d wr_valid=%0d exp reject=1 wr_valid=0", reject, wr_valid); end
        @(negedge clk);
        checks++; if ({reject, wr_valid, player} !== 3'b000) begin errors++;
            $display("FAIL full_after: got reject=%0d wr_valid=%0d player=%0d exp 0 0 0", reject, wr_valid, player); end
    endtask

    task automatic test_win();
        logic v, p;
        logic [2:0] c, r;
        press_new();
        do_drop(1'b0, v, c, r, p);
        do_drop(1'b1, v, c, r, p);
        checks++; if ({game_over, winner} !== {1'b1, 2'd2}) begin errors++;
            $display("FAIL win_p2: got game_over=%0d winner=%0d exp 1 2", game_over, winner); end
        @(negedge clk) btn_drop = 1'b1;
        @(negedge clk) begin btn_drop = 1'b0; btn_left = 1'b1; end
        @(negedge clk) btn_left = 1'b0;
        checks++; if ({wr_valid, cursor_col, game_over, winner} !== {1'b0, 3'd3, 1'b1, 2'd2}) begin errors++;
            $display("FAIL game_over_frozen: got v=%0d cur=%0d go=%0d win=%0d exp 0 3 1 2",
                     wr_valid, cursor_col, game_over, winner); end
    endtask

    task automatic test_draw();
        logic v, p;
        logic [2:0] c, r;
        press_new();
        for (int col = 0; col < 7; col++) begin
            goto_col(col);
            for (int i = 0; i < 6; i++) begin
                if (col == 6 && i == 5) begin
                    checks++; if ({game_over, player} !== 2'b01) begin errors++;
                        $display("FAIL draw_before_last: got go=%0d player=%0d exp 0 1", game_over, player); end
                end
                do_drop(1'b0, v, c, r, p);
            end
        end
        checks++; if ({game_over, winner} !== {1'b1, 2'd3}) begin errors++;
            $display("FAIL draw: got game_over=%0d winner=%0d exp 1 3", game_over, winner); end
    endtask

    task automatic test_new_in_write();
        logic v, p;
        logic [2:0] c, r;
        @(negedge clk) btn_new = 1'b1;
        @(negedge clk) btn_new = 1'b0;
        checks++; if ({new_game, game_over, winner} !== {1'b1, 1'b0, 2'd0}) begin errors++;
            $display("FAIL new_from_game_over: got ng=%0d go=%0d win=%0d exp 1 0 0", new_game, game_over, winner); end
        do_drop(1'b0, v, c, r, p);
        @(negedge clk) btn_drop = 1'b1;
        @(negedge clk) btn_drop = 1'b0;
        checks++; if ({wr_valid, wr_row, wr_player} !== {1'b1, 3'd1, 1'b1}) begin errors++;
            $display("FAIL second_drop: got v=%0d r=%0d p=%0d exp 1 1 1", wr_valid, wr_row, wr_player); end
        btn_new = 1'b1;
        @(negedge clk) btn_new = 1'b0;
        checks++; if ({wr_valid, new_game, cursor_col, player} !== {1'b0, 1'b1, 3'd3, 1'b0}) begin errors++;
            $display("FAIL new_in_write: got v=%0d ng=%0d cur=%0d p=%0d exp 0 1 3 0",
                     wr_valid, new_game, cursor_col, player); end
        @(negedge clk);
        checks++; if (new_game !== 1'b0) begin errors++; $display("FAIL new_game_pulse: got %0d exp 0", new_game); end
        do_drop(1'b0, v, c, r, p);
        checks++; if ({v, r, p} !== {1'b1, 3'd0, 1'b0}) begin errors++;
            $display("FAIL heights_cleared: got v=%0d r=%0d p=%0d exp 1 0 0", v, r, p); end
    endtask

    task automatic test_async_reset();
        logic v, p;
        logic [2:0] c, r;
        press_new();
        press_left();
        do_drop(1'b0, v, c, r, p);
        @(negedge clk) btn_drop = 1'b1;
        @(negedge clk) begin btn_drop = 1'b0; wr_ready = 1'b1; end
        @(negedge clk) wr_ready = 1'b0;
        checks++; if ({player, cursor_col, wr_valid} !== {1'b1, 3'd2, 1'b0}) begin errors++;
            $display("FAIL pre_reset_check: got p=%0d cur=%0d v=%0d exp 1 2 0", player, cursor_col, wr_valid); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({player, cursor_col, wr_valid, game_over, winner} !== {1'b0, 3'd3, 1'b0, 1'b0, 2'd0}) begin errors++;
            $display("FAIL async_reset: got p=%0d cur=%0d v=%0d go=%0d win=%0d exp 0 3 0 0 0",
                     player, cursor_col, wr_valid, game_over, winner); end
        @(negedge clk) reset = 1'b0;
        do_drop(1'b0, v, c, r, p);
        checks++; if ({v, c, r, p} !== {1'b1, 3'd3, 3'd0, 1'b0}) begin errors++;
            $display("FAIL after_reset_drop: got v=%0d c=%0d r=%0d p=%0d exp 1 3 0 0", v, c, r, p); end
    endtask

    initial begin
        test_reset();
        test_cursor();
        test_write_hold();
        test_column_full();
        test_win();
        test_draw();
        test_new_in_write();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog: the directed sequence is far shorter than this
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
